// File: rtl/rshift_pipe_pkg.sv
// ---------------------------------------------------------------------------
// rshift_pipe_pkg
// Shared ALU shift definitions: shift-kind decoding and a constant-foldable
// log2 helper used to size the shift pipeline.
// ---------------------------------------------------------------------------
package rshift_pipe_pkg;

    // Decoding of the in_arith control bit.
    typedef enum logic {
        SHIFT_LOGICAL = 1'b0,
        SHIFT_ARITH   = 1'b1
    } shift_kind_e;

    // Ceiling log2 of a width; usable in localparam expressions.
    function automatic int unsigned log2w(input int unsigned w);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < w) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : rshift_pipe_pkg

// File: rtl/rshift_stage.sv
// ---------------------------------------------------------------------------
// rshift_stage
// One registered stage of the right barrel shifter. Conditionally shifts the
// upstream data right by 2^K, filling vacated bits with the captured fill
// bit, and carries the valid, fill and shift-amount bits alongside.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   adv        stage load enable (hold all registers when low)
//   up_valid   upstream valid bit
//   up_data    upstream data
//   up_fill    fill bit captured at acceptance
//   up_bits    full shift amount (only bit K is acted on here)
//   v, d, f, b registered valid, data, fill and shift-amount bits
// ---------------------------------------------------------------------------
module rshift_stage
    import rshift_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned K      = 0,
    parameter int unsigned STAGES = log2w(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic              up_valid,
    input  logic [WIDTH-1:0]  up_data,
    input  logic              up_fill,
    input  logic [STAGES-1:0] up_bits,
    output logic              v,
    output logic [WIDTH-1:0]  d,
    output logic              f,
    output logic [STAGES-1:0] b
);

    localparam int unsigned SH = 32'd1 << K;

    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] shifted;

    // Ones in the top SH bit positions: the bits vacated by the shift.
    assign fill_mask = ~({WIDTH{1'b1}} >> SH);

    // Shift by 2^K when this stage's amount bit is set.
    always_comb begin
        shifted = up_data;
        if (up_bits[K]) begin
            shifted = (up_data >> SH) | (up_fill ? fill_mask : '0);
        end
    end

    // Stage registers; reset wins over any advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            d <= '0;
            f <= 1'b0;
            b <= '0;
        end else if (adv) begin
            v <= up_valid;
            d <= shifted;
            f <= up_fill;
            b <= up_bits;
        end
    end

endmodule : rshift_stage

// File: rtl/rshift_pipe.sv
// ---------------------------------------------------------------------------
// rshift_pipe
// Pipelined logical/arithmetic right barrel shifter with valid/ready
// handshakes on both sides. One registered stage per shift-amount bit;
// bubbles collapse so a stalled pipe still fills up to STAGES results.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   in_valid   operand valid
//   in_ready   operand accepted this cycle (combinational on out_ready/valids)
//   in_a       value to shift
//   in_b       shift amount (low STAGES bits used)
//   in_arith   1 = sign fill, 0 = zero fill
//   out_valid  out_s holds a result
//   out_ready  consumer takes the result this cycle
//   out_s      shifted result
// ---------------------------------------------------------------------------
module rshift_pipe
    import rshift_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s
);

    localparam int unsigned STAGES = log2w(WIDTH);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] f;
    logic [STAGES-1:0] adv;
    logic [WIDTH-1:0]  d [STAGES];
    logic [STAGES-1:0] b [STAGES];

    shift_kind_e kind;
    logic        in_fill;

    // Fill bit is fixed at acceptance from the original operand's sign.
    assign kind    = shift_kind_e'(in_arith);
    assign in_fill = (kind == SHIFT_ARITH) && in_a[WIDTH-1];

    // Advance chain: a stage moves if it is empty or the one after it moves.
    always_comb begin
        adv             = '0;
        adv[STAGES-1]   = v[STAGES-1] ? out_ready : 1'b1;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            adv[k] = !v[k] || adv[k+1];
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v[STAGES-1];
    assign out_s     = d[STAGES-1];

    for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
        logic              up_valid;
        logic [WIDTH-1:0]  up_data;
        logic              up_fill;
        logic [STAGES-1:0] up_bits;

        if (k == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_a;
            assign up_fill  = in_fill;
            assign up_bits  = in_b[STAGES-1:0];
        end else begin : g_body
            assign up_valid = v[k-1];
            assign up_data  = d[k-1];
            assign up_fill  = f[k-1];
            assign up_bits  = b[k-1];
        end

        rshift_stage #(
            .WIDTH  (WIDTH),
            .K      (k),
            .STAGES (STAGES)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .adv      (adv[k]),
            .up_valid (up_valid),
            .up_data  (up_data),
            .up_fill  (up_fill),
            .up_bits  (up_bits),
            .v        (v[k]),
            .d        (d[k]),
            .f        (f[k]),
            .b        (b[k])
        );
    end

    // Tail fill/amount bits and the ignored high amount bits have no consumer.
    logic unused_bits;
    assign unused_bits = ^{f[STAGES-1], b[STAGES-1], in_b[WIDTH-1:STAGES]};

endmodule : rshift_pipe

// File: tb/tb_rshift_pipe.sv
// ---------------------------------------------------------------------------
// tb_rshift_pipe
// Directed and scoreboarded bench for rshift_pipe (WIDTH = 32).
// ---------------------------------------------------------------------------
module tb_rshift_pipe;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STAGES = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_arith;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_s;

    always #5 clk = ~clk;

    rshift_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_arith  (in_arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                              input logic arith);
        logic [4:0] amt;
        amt = b[4:0];
        if (arith) return 32'($signed(a) >>> amt);
        return a >> amt;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operand through an empty pipe with out_ready high.
    task automatic run_single(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic arith, input logic [31:0] exp);
        int lat;
        in_a      = a;
        in_b      = b;
        in_arith  = arith;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 12);
        check({tag, "_latency"}, 32'(lat), 32'(STAGES - 1));
        check({tag, "_out_s"}, out_s, exp);
        tick();
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    logic [31:0] exp_q[$];

    initial begin
        logic [31:0] pa, pb, ea, eb, held;
        logic        parith, have_hold, saw_full, ready_ok;
        int          sent, got_n, cyc, vcount;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_arith  = 1'b0;
        out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_s", out_s, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Directed single operations
        run_single("lsr4",    32'hF000_0000, 32'd4,          1'b0, 32'h0F00_0000);
        run_single("asr31",   32'h8000_0010, 32'd31,         1'b1, 32'hFFFF_FFFF);
        run_single("lsr31",   32'h8000_0010, 32'd31,         1'b0, 32'h0000_0001);
        run_single("upper",   32'h1234_5678, 32'h0000_0120,  1'b0, 32'h1234_5678);
        run_single("asr0",    32'h8765_4321, 32'd0,          1'b1, 32'h8765_4321);
        run_single("asr7",    32'h8000_0000, 32'd7,          1'b1, 32'hFF00_0000);
        run_single("asr_pos", 32'h7000_0000, 32'd3,          1'b1, 32'h0E00_0000);

        // Streaming with out_ready pattern 1,0,0,1
        sent      = 0;
        got_n     = 0;
        cyc       = 0;
        have_hold = 1'b0;
        held      = '0;
        saw_full  = 1'b0;
        pa        = $urandom();
        pb        = $urandom();
        parith    = 1'(($urandom() & 1));
        while ((sent < 20 || exp_q.size() != 0) && cyc < 300) begin
            in_valid  = (sent < 20);
            in_a      = pa;
            in_b      = pb;
            in_arith  = parith;
            out_ready = (sent >= 20) || (cyc % 4 == 0) || (cyc % 4 == 3);
            #2;
            ready_ok = (exp_q.size() < STAGES) || out_ready;
            check("stream_in_ready", 32'(in_ready), 32'(ready_ok));
            if (!in_ready) saw_full = 1'b1;
            if (have_hold) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_stable", out_s, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_extra", 32'(out_valid), 32'd0);
                end else begin
                    check("stream_data", out_s, exp_q.pop_front());
                end
                got_n++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_shift(pa, pb, parith));
                sent++;
                pa     = $urandom();
                pb     = $urandom();
                parith = 1'(($urandom() & 1));
                if (sent % 5 == 1) pa[31] = 1'b1;
            end
            have_hold = out_valid && !out_ready;
            held      = out_s;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_done_in_time", 32'(cyc < 300), 32'd1);
        check("stream_count", 32'(got_n), 32'd20);
        check("stream_saw_full", 32'(saw_full), 32'd1);
        exp_q.delete();

        // Reset mid-stream
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_arith  = 1'b0;
        in_b      = 32'd1;
        in_a      = 32'hAAAA_0001;
        tick();
        in_a = 32'hAAAA_0002;
        tick();
        in_a = 32'hAAAA_0003;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_out_s", out_s, 32'd0);
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) vcount++;
        end
        check("midrst_no_ghost", 32'(vcount), 32'd0);
        run_single("post_rst", 32'h0000_FF00, 32'd8, 1'b0, 32'h0000_00FF);

        // Bubble collapse under backpressure
        out_ready = 1'b0;
        ea        = 32'hC000_0000;
        eb        = 32'h0000_0000;
        in_a      = ea;
        in_b      = 32'd2;
        in_arith  = 1'b1;
        in_valid  = 1'b1;
        #1;
        check("bub_rdy_a", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        in_a     = 32'h0001_0000;
        in_b     = 32'd16;
        in_arith = 1'b0;
        in_valid = 1'b1;
        #1;
        check("bub_rdy_b", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        vcount   = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (!in_ready) vcount++;
        end
        check("bub_ready_held", 32'(vcount), 32'd0);
        check("bub_head_valid", 32'(out_valid), 32'd1);
        check("bub_head_data", out_s, 32'hF000_0000);
        check("bub_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        tick();
        eb = 32'h0000_0001;
        check("bub_second_valid", 32'(out_valid), 32'd1);
        check("bub_second_data", out_s, eb);
        tick();
        check("bub_drained", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rshift_pipe
